tape_sdram_arbiter: RTL

//  Shares one SDRAM controller port between the tape-image download writer (ioctl) and the cassette player reader.

---
 rtl/tape_sdram_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tape_sdram_arbiter.sv
// Arbitrates one SDRAM port between the tape download writer and the cassette reader.
// Optional ARB_ROUND_ROBIN_EN alternates contended grants; otherwise writes have fixed priority.
module tape_sdram_arbiter #(
  parameter int AW     = 25,
  parameter int TO_CYC = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_busy,
  input  logic          cas_rd,
  input  logic [AW-1:0] cas_addr,
  output logic [7:0]    cas_data,
  output logic          cas_eot,
  output logic [AW-1:0] tape_len,
  output logic [AW-1:0] sd_addr,
  output logic [7:0]    sd_din,
  output logic          sd_we,
  output logic          sd_rd,
  input  logic          sd_ack,
  input  logic [7:0]    sd_dout
);

  localparam int CW = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] to_cnt;
  logic          wr_pend, rd_pend;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data;
  logic          cas_rd_q, dl_active_q;
  logic          cas_edge, act_rise, timeout, pick_wr;
  logic [AW-1:0] len_next;

  assign cas_edge = cas_rd & ~cas_rd_q & ~dl_active;
  assign act_rise = dl_active & ~dl_active_q;
  assign timeout  = (to_cnt == CW'(TO_CYC - 1)) && !sd_ack;
  assign len_next = sd_addr + AW'(1);
  assign dl_busy  = wr_pend | (state == WR);
  assign cas_eot  = (tape_len != '0) && (cas_addr >= tape_len);

`ifdef ARB_ROUND_ROBIN_EN
  // Preference starts on write, then flips to the loser after every contended grant.
  logic turn_wr;
  assign pick_wr = wr_pend & (~rd_pend | turn_wr);
`else
  assign pick_wr = wr_pend;
`endif

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    sd_we    = 1'b0;
    sd_rd    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_wr)      state_nx = WR;
        else if (rd_pend) state_nx = RD;
      end
      WR: begin
        sd_we = 1'b1;
        if (sd_ack || timeout) state_nx = IDLE;
      end
      RD: begin
        sd_rd = 1'b1;
        if (sd_ack || timeout) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      to_cnt      <= '0;
      wr_pend     <= 1'b0;
      rd_pend     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_addr     <= '0;
      cas_rd_q    <= 1'b0;
      dl_active_q <= 1'b0;
      cas_data    <= '0;
      tape_len    <= '0;
      sd_addr     <= '0;
      sd_din      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      turn_wr     <= 1'b1;
`endif
    end else begin
      state       <= state_nx;
      cas_rd_q    <= cas_rd;
      dl_active_q <= dl_active;
      to_cnt      <= (state == IDLE) ? '0 : to_cnt + CW'(1);

      // Later assignments win: a new strobe beats completion of the previous transaction.
      if (state == WR && state_nx == IDLE) wr_pend <= 1'b0;
      if (dl_wr) begin
        wr_pend <= 1'b1;
        wr_addr <= dl_addr;
        wr_data <= dl_data;
      end

      if (state == RD && state_nx == IDLE) rd_pend <= 1'b0;
      if (act_rise) rd_pend <= 1'b0;
      if (cas_edge) begin
        rd_pend <= 1'b1;
        rd_addr <= cas_addr;
      end

      // Address/data are loaded only on the grant edge, so they stay put for the whole request.
      if (state == IDLE && state_nx == WR) begin
        sd_addr <= wr_addr;
        sd_din  <= wr_data;
      end
      if (state == IDLE && state_nx == RD) sd_addr <= rd_addr;

      if (state == RD && sd_ack) cas_data <= sd_dout;

      if (state == WR && sd_ack && len_next != '0 && len_next > tape_len) tape_len <= len_next;
      if (act_rise) tape_len <= '0;

`ifdef ARB_ROUND_ROBIN_EN
      if (state == IDLE && wr_pend && rd_pend) turn_wr <= ~turn_wr;
`endif
    end
  end

endmodule
